// File: rtl/qspi_mem_ctrl.sv
// qspi_mem_ctrl: single-byte QSPI initiator for the flash and two PSRAMs on
// the QSPI Pmod. One request becomes one CS-framed transaction:
// CMD / ADDR / (MODE / DUMMY) / DATA, four bits per SCK, SCK = clk/2.
// Pads are decoded combinationally from the registered state, so the
// asynchronous reset puts them back to idle values without a clock edge.
module qspi_mem_ctrl #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int DUMMY_CYCLES  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_target,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [7:0]               req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_err,
    output logic [7:0]               rsp_rdata,
    output logic [7:0]               uio_out,
    output logic [7:0]               uio_oe,
    input  logic [7:0]               uio_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_SELECT, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DESELECT, S_RESP
    } state_t;

    // Phase lengths in clk cycles (two clk per SCK period).
    localparam int CW = 16;
    localparam logic [CW-1:0] CMD_LEN   = CW'(4);
    localparam logic [CW-1:0] ADDR_LEN  = CW'(12);
    localparam logic [CW-1:0] MODE_LEN  = CW'(4);
    localparam logic [CW-1:0] DUMMY_LEN = CW'(2 * DUMMY_CYCLES);
    localparam logic [CW-1:0] DATA_LEN  = CW'(4);

    localparam logic [7:0] OP_READ  = 8'hEB;
    localparam logic [7:0] OP_WRITE = 8'h38;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           write_q, write_d;
    logic           err_q, err_d;
    logic [1:0]     tgt_q, tgt_d;
    logic [23:0]    addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rdata_q, rdata_d;

    logic [ADDRESS_WIDTH+23:0] addr_ext;
    logic [23:0]    req_addr24;
    logic [CW-1:0]  phase_len;
    logic           phase_last;
    logic [2:0]     nib_idx;
    logic [3:0]     nib_in;
    logic [3:0]     nib_out;
    logic [23:0]    addr_sh;
    logic [7:0]     op;
    logic [2:0]     cs_n;       // {RAM B, RAM A, flash}
    logic           sck;
    logic           sd_oe;
    logic           unused_bits;

    assign nib_in  = {uio_in[5], uio_in[4], uio_in[2], uio_in[1]};
    assign nib_idx = cnt_q[3:1];
    assign op      = write_q ? OP_WRITE : OP_READ;
    assign addr_sh = addr_q << {nib_idx, 2'b00};

    assign unused_bits = ^{uio_in[7:6], uio_in[3], uio_in[0], addr_ext[ADDRESS_WIDTH+23:24]};

    // Zero-extend or truncate the request address to the 24 bits on the wire.
    always_comb begin
        addr_ext = '0;
        addr_ext[ADDRESS_WIDTH-1:0] = req_addr;
        req_addr24 = addr_ext[23:0];
    end

    // Length of the current clocked phase and its last-cycle flag.
    always_comb begin
        phase_len = CMD_LEN;
        case (state_q)
            S_ADDR:  phase_len = ADDR_LEN;
            S_MODE:  phase_len = MODE_LEN;
            S_DUMMY: phase_len = DUMMY_LEN;
            S_DATA:  phase_len = DATA_LEN;
            default: phase_len = CMD_LEN;
        endcase
        phase_last = (cnt_q == phase_len - CW'(1));
    end

    // State register and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            tgt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: phase sequencing, request capture, read-nibble capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        write_d = write_q;
        err_d   = err_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    write_d = req_write;
                    tgt_d   = req_target;
                    addr_d  = req_addr24;
                    wdata_d = req_wdata;
                    err_d   = (req_target == 2'd3) || (req_write && req_target == 2'd0);
                    state_d = err_d ? S_RESP : S_SELECT;
                end
            end
            S_SELECT: begin
                cnt_d   = '0;
                state_d = S_CMD;
            end
            S_CMD: if (phase_last) begin
                cnt_d   = '0;
                state_d = S_ADDR;
            end
            S_ADDR: if (phase_last) begin
                cnt_d   = '0;
                state_d = write_q ? S_DATA : S_MODE;
            end
            S_MODE: if (phase_last) begin
                cnt_d   = '0;
                state_d = (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
            end
            S_DUMMY: if (phase_last) begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                // Capture on the edge that ends the SCK high phase.
                if (!write_q && cnt_q[0]) rdata_d = {rdata_q[3:0], nib_in};
                if (phase_last) begin
                    cnt_d   = '0;
                    state_d = S_DESELECT;
                end
            end
            S_DESELECT: begin
                cnt_d   = '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Pad decode: chip select, SCK (low phase on even counts) and SD nibble.
    always_comb begin
        cs_n    = 3'b111;
        sck     = 1'b0;
        sd_oe   = 1'b0;
        nib_out = 4'h0;
        if (state_q inside {S_SELECT, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA}) begin
            case (tgt_q)
                2'd0:    cs_n = 3'b110;
                2'd1:    cs_n = 3'b101;
                2'd2:    cs_n = 3'b011;
                default: cs_n = 3'b111;
            endcase
        end
        case (state_q)
            S_CMD: begin
                sck     = cnt_q[0];
                sd_oe   = 1'b1;
                nib_out = (nib_idx == 3'd0) ? op[7:4] : op[3:0];
            end
            S_ADDR: begin
                sck     = cnt_q[0];
                sd_oe   = 1'b1;
                nib_out = addr_sh[23:20];
            end
            S_MODE: begin
                sck   = cnt_q[0];
                sd_oe = 1'b1;
            end
            S_DUMMY: sck = cnt_q[0];
            S_DATA: begin
                sck = cnt_q[0];
                if (write_q) begin
                    sd_oe   = 1'b1;
                    nib_out = (nib_idx == 3'd0) ? wdata_q[7:4] : wdata_q[3:0];
                end
            end
            default: ;
        endcase
    end

    assign uio_out   = {cs_n[2], cs_n[1], nib_out[3], nib_out[2], sck, nib_out[1], nib_out[0], cs_n[0]};
    assign uio_oe    = {1'b1, 1'b1, sd_oe, sd_oe, 1'b1, sd_oe, sd_oe, 1'b1};
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = (state_q == S_RESP) && err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// Bench for qspi_mem_ctrl: directed request table against a pin-level
// QSPI responder model (flash + two RAMs), plus back-to-back and
// reset-during-read sequences.
module tb_qspi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_target = 2'd0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [7:0]  uio_in = '0;

    qspi_mem_ctrl #(.ADDRESS_WIDTH(24), .DUMMY_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_target(req_target), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .uio_out(uio_out), .uio_oe(uio_oe), .uio_in(uio_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- responder model (samples pads mid-cycle) ----------------
    logic [7:0]  mem [3][256];
    logic [39:0] sr = '0;
    int          rises = 0;
    logic        sck_prev = 1'b0;
    int          rtgt = 0;
    logic [3:0]  nib_o;
    logic [3:0]  nib_q [$];

    function automatic logic [7:0] pads_in(input logic [3:0] d);
        return {2'b00, d[3], d[2], 1'b0, d[1], d[0], 1'b0};
    endfunction

    always @(negedge clk) begin
        nib_o = {uio_out[5], uio_out[4], uio_out[2], uio_out[1]};
        if (uio_out[0] && uio_out[6] && uio_out[7]) begin
            rises = 0;
            sr    = '0;
        end else begin
            rtgt = !uio_out[0] ? 0 : (!uio_out[6] ? 1 : 2);
            if (uio_out[3] && !sck_prev) begin
                if (rises < 10) sr = {sr[35:0], nib_o};
                if (uio_oe[1]) nib_q.push_back(nib_o);
                rises++;
                if (rises == 10 && sr[39:32] == 8'h38) mem[rtgt][sr[15:8]] = sr[7:0];
            end else if (!uio_out[3] && sr[39:32] == 8'hEB) begin
                if (rises == 14) uio_in = pads_in(mem[rtgt][sr[15:8]][7:4]);
                else if (rises == 15) uio_in = pads_in(mem[rtgt][sr[15:8]][3:0]);
            end
        end
        sck_prev = uio_out[3];
    end

    // ---------------- directed request table ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  tgt;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic        err;
        logic [7:0]  rdata;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic run_req(input vec_t v, input string tag);
        int lat = 0, cs_low = 0, sck_rise = 0, rdy_hi = 0, bad_oe = 0, other_cs = 0;
        logic prev_sck = 1'b0, got = 1'b0, pad_moved = 1'b0, got_err = 1'b0;
        logic [7:0] got_rdata = '0;
        logic [39:0] exp_nibs, got_nibs;
        int cs_bit;
        cs_bit = (v.tgt == 2'd0) ? 0 : (v.tgt == 2'd1) ? 6 : 7;
        @(negedge clk);
        check({tag, "_ready_idle"}, req_ready, 1'b1);
        nib_q.delete();
        req_valid = 1'b1; req_write = v.wr; req_target = v.tgt;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1;
        // Garbage while busy: must be ignored.
        req_valid = 1'b0; req_target = 2'd3; req_addr = 24'hFFFFFF; req_wdata = 8'hFF;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1'b1; got_err = rsp_err; got_rdata = rsp_rdata;
            end
            if (req_ready) rdy_hi++;
            if (v.err && (uio_out !== 8'hC1 || uio_oe !== 8'hC9)) pad_moved = 1'b1;
            if (uio_out[0] && uio_out[6] && uio_out[7] && uio_oe !== 8'hC9) bad_oe++;
            if (!v.err) begin
                if (!uio_out[cs_bit]) cs_low++;
                for (int b = 0; b < 8; b++)
                    if ((b == 0 || b == 6 || b == 7) && b != cs_bit && !uio_out[b]) other_cs++;
                if (uio_out[3] && !prev_sck) sck_rise++;
                prev_sck = uio_out[3];
                if (!v.wr && lat == 21) check({tag, "_oe_mode_end"}, uio_oe, 8'hFF);
                if (!v.wr && lat == 22) check({tag, "_oe_dummy_first"}, uio_oe, 8'hC9);
            end
        end
        check({tag, "_rsp_seen"}, got, 1'b1);
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_rsp_err"}, got_err, v.err);
        if (!v.wr && !v.err) check({tag, "_rdata"}, got_rdata, v.rdata);
        check({tag, "_ready_busy"}, rdy_hi, 0);
        check({tag, "_sd_oe_while_deselected"}, bad_oe, 0);
        if (v.err) begin
            check({tag, "_pads_quiet"}, pad_moved, 1'b0);
        end else begin
            check({tag, "_cs_low_cycles"}, cs_low, v.wr ? 21 : 33);
            check({tag, "_sck_count"}, sck_rise, v.wr ? 10 : 16);
            check({tag, "_other_cs"}, other_cs, 0);
            exp_nibs = {(v.wr ? 8'h38 : 8'hEB), v.addr, (v.wr ? v.wdata : 8'h00)};
            got_nibs = '0;
            for (int i = 0; i < nib_q.size() && i < 10; i++) got_nibs = {got_nibs[35:0], nib_q[i]};
            check({tag, "_nibble_count"}, nib_q.size(), 10);
            check({tag, "_nibbles"}, got_nibs, exp_nibs);
        end
    endtask

    initial begin
        int cyc, first_rsp, acc2, rsp2, cs_high, stray;
        vec_t fresh;
        for (int t = 0; t < 3; t++)
            for (int a = 0; a < 256; a++) mem[t][a] = 8'h00;
        mem[0][1] = 8'h5A;
        mem[0][2] = 8'hA5;

        //          wr    tgt   addr         wdata  err   rdata  lat
        vecs[0] = '{1'b0, 2'd0, 24'h000001, 8'h00, 1'b0, 8'h5A, 35};
        vecs[1] = '{1'b1, 2'd1, 24'h000010, 8'hC3, 1'b0, 8'h00, 23};
        vecs[2] = '{1'b0, 2'd1, 24'h000010, 8'h00, 1'b0, 8'hC3, 35};
        vecs[3] = '{1'b1, 2'd0, 24'h000004, 8'h11, 1'b1, 8'h00, 1};
        vecs[4] = '{1'b0, 2'd3, 24'h000001, 8'h00, 1'b1, 8'h00, 1};
        vecs[5] = '{1'b1, 2'd2, 24'h000020, 8'h7E, 1'b0, 8'h00, 23};
        vecs[6] = '{1'b0, 2'd2, 24'h000020, 8'h00, 1'b0, 8'h7E, 35};
        vecs[7] = '{1'b0, 2'd1, 24'h000020, 8'h00, 1'b0, 8'h00, 35};
        vecs[8] = '{1'b0, 2'd0, 24'h000002, 8'h00, 1'b0, 8'hA5, 35};

        // Reset values.
        #12;
        check("reset_uio_out", uio_out, 8'hC1);
        check("reset_uio_oe", uio_oe, 8'hC9);
        check("reset_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rdata", rsp_rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_req(vecs[i], $sformatf("v%0d", i));

        // Back-to-back reads with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_target = 2'd0; req_addr = 24'h000001;
        @(posedge clk);
        #1 req_addr = 24'h000002;
        cyc = 0; first_rsp = -1; acc2 = -1; rsp2 = -1; cs_high = 0;
        while (rsp2 < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (acc2 < 0 && uio_out[0]) cs_high++;
            if (rsp_valid) begin
                if (first_rsp < 0) begin
                    first_rsp = cyc;
                    check("b2b_first_rdata", rsp_rdata, 8'h5A);
                end else begin
                    rsp2 = cyc;
                    check("b2b_second_rdata", rsp_rdata, 8'hA5);
                end
            end
            if (first_rsp < 0 && req_ready) check("b2b_ready_busy", req_ready, 1'b0);
            if (first_rsp >= 0 && acc2 < 0 && req_ready) begin
                acc2 = cyc;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        check("b2b_first_latency", first_rsp, 35);
        check("b2b_second_accept", acc2, first_rsp + 1);
        check("b2b_second_latency", rsp2 - acc2, 35);
        check("b2b_cs_gap_ge2", (cs_high >= 2), 1'b1);

        // Reset asserted during DUMMY of a flash read.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_target = 2'd0; req_addr = 24'h000001;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (24) @(negedge clk);
        check("rst_mid_dummy_oe", uio_oe, 8'hC9);
        check("rst_mid_cs_low", uio_out[0], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_uio_out", uio_out, 8'hC1);
        check("rst_async_uio_oe", uio_oe, 8'hC9);
        check("rst_async_ready", req_ready, 1'b1);
        check("rst_async_rdata", rsp_rdata, 8'h00);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        check("rst_no_rsp", stray, 0);
        fresh = '{1'b0, 2'd0, 24'h000001, 8'h00, 1'b0, 8'h5A, 35};
        run_req(fresh, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
